note_sample_player: RTL

//  Parametrised ROM-backed note player feeding the Audio_Controller output FIFO. Holds NUM_NOTES

---
 rtl/note_sample_player.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/note_sample_player.sv
// note_sample_player
//   Plays one of NUM_NOTES sample tables stored back to back in an external
//   synchronous ROM. Samples are fetched at CLOCK_50/RATE_DIV, scaled by an
//   arithmetic volume shift and offered to the Audio_Controller output FIFO
//   under audio_out_allowed flow control. Supports one-shot or looped playback,
//   stop, and mono/stereo output.
// Ports
//   CLOCK_50                 system clock, rising edge
//   reset                    synchronous, active-high
//   play / stop              start request (IDLE only) / abort playback
//   loop_en                  wrap table end to offset 0 (sampled at table end)
//   note_sel                 note table, latched when play is accepted
//   vol_shift                arithmetic right shift of the output sample
//   rom_addr / rom_q         ROM read address (registered) / ROM data
//   audio_out_allowed        FIFO has space
//   write_audio_out          one-cycle write strobe
//   left/right_channel_audio_out  output samples
//   busy / done / overrun    playing / one-shot complete pulse / sticky overwrite flag
module note_sample_player #(
  parameter int SAMPLE_W   = 3,
  parameter int SAMPLE_LEN = 5001,
  parameter int NUM_NOTES  = 4,
  parameter int NOTE_W     = 2,
  parameter int ROM_ADDR_W = 15,
  parameter int RATE_DIV   = 1200,
  parameter int OUT_W      = 32,
  parameter int STEREO     = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [NOTE_W-1:0]     note_sel,
  input  logic [1:0]            vol_shift,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [SAMPLE_W-1:0]   rom_q,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [OUT_W-1:0]      left_channel_audio_out,
  output logic [OUT_W-1:0]      right_channel_audio_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int OFF_W = (SAMPLE_LEN > 1) ? $clog2(SAMPLE_LEN) : 1;
  localparam int DIV_W = $clog2(RATE_DIV);
  localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(NUM_NOTES - 1);
  localparam logic [OFF_W-1:0]  END_OFF   = OFF_W'(SAMPLE_LEN - 1);
  localparam logic [DIV_W-1:0]  DIV_END   = DIV_W'(RATE_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, LAST} state_t;

  state_t                  state, next_state;
  logic [DIV_W-1:0]        div_cnt;
  logic [OFF_W-1:0]        offset;
  logic [NOTE_W-1:0]       note_q;
  logic [SAMPLE_W-1:0]     sample_reg;
  logic                    pending;
  logic                    rd_v1, rd_v2;
  logic                    done_q;
  logic                    accept, abort, tick, table_end, latch, write_int;
  logic [NOTE_W-1:0]       note_clamped;
  logic [ROM_ADDR_W-1:0]   base_addr;
  logic signed [OUT_W-1:0] aligned;

  assign accept       = (state == IDLE) && play && !stop;
  assign abort        = (state != IDLE) && stop;
  assign tick         = (state == PLAY) && (div_cnt == DIV_END);
  assign table_end    = (offset == END_OFF);
  // rd_v2 marks the edge where rom_q holds the sample addressed two edges ago
  assign latch        = rd_v2 && !abort;
  assign write_int    = pending && audio_out_allowed;
  assign note_clamped = (note_sel > LAST_NOTE) ? LAST_NOTE : note_sel;
  assign base_addr    = ROM_ADDR_W'(note_q) * ROM_ADDR_W'(SAMPLE_LEN);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; stop outranks both the tick and the table-end move to LAST
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = PLAY;
      PLAY: begin
        if (stop)                               next_state = IDLE;
        else if (tick && table_end && !loop_en) next_state = LAST;
      end
      LAST: begin
        if (stop)       next_state = IDLE;
        else if (rd_v2) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (state == PLAY) || (state == LAST);
  end

  // Rate divider, table offset and ROM address generation
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt  <= '0;
      offset   <= '0;
      note_q   <= '0;
      rom_addr <= '0;
    end else if (accept) begin
      note_q  <= note_clamped;
      offset  <= '0;
      div_cnt <= '0;
    end else if (state == PLAY && !stop) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        rom_addr <= base_addr + ROM_ADDR_W'(offset);
        offset   <= table_end ? '0 : offset + 1'b1;
      end
    end
  end

  // Read pipeline, sample holding register and FIFO handshake.
  // A sample that lands while the previous one is still unwritten replaces it
  // and flags overrun; if the old one is being written that same cycle, no loss.
  // In IDLE the register is cleared only once any final sample has been written.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      sample_reg <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_v1  <= tick && !stop;
      rd_v2  <= rd_v1 && !abort;
      done_q <= (state == LAST) && rd_v2 && !stop;
      if (abort) begin
        sample_reg <= '0;
        pending    <= 1'b0;
      end else if (latch) begin
        sample_reg <= rom_q;
        pending    <= 1'b1;
        if (pending && !write_int) overrun <= 1'b1;
      end else begin
        if (write_int) pending <= 1'b0;
        if (state == IDLE && !pending) sample_reg <= '0;
      end
    end
  end

  assign write_audio_out = write_int && !reset;
  assign done            = done_q && !reset;

  // MSB-align the sample so the shift attenuates while preserving sign
  assign aligned                 = {sample_reg, {(OUT_W - SAMPLE_W){1'b0}}};
  assign left_channel_audio_out  = aligned >>> vol_shift;
  assign right_channel_audio_out = (STEREO != 0) ? left_channel_audio_out : '0;

endmodule
